// File: rtl/datapath_ctrl.sv
// rtl/datapath_ctrl.sv - step/clear command sequencer for the up/down counter datapath
// Every output is a register updated alongside the state, so pulses line up with state cycles.
module datapath_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_clr,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_n,
    input  logic             cmd_sat,
    input  logic             z,
    input  logic             m,
    output logic             op,
    output logic             c_ld,
    output logic             c_clr,
    output logic             busy,
    output logic             done,
    output logic             sat_hit,
    output logic [CNT_W-1:0] steps_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_STEP,
        S_GAP,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q;
    logic             ready_q;
    logic             op_q;
    logic             sat_q;
    logic             ld_q;
    logic             clr_q;
    logic             busy_q;
    logic             done_q;
    logic             sat_hit_q;
    logic [CNT_W-1:0] remaining_q;
    logic [CNT_W-1:0] steps_q;

    logic at_floor;
    logic accept;

    // z/m describe the value the previous c_ld already produced
    assign at_floor = z || m;
    assign accept   = cmd_valid && ready_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ready_q     <= 1'b1;
            op_q        <= 1'b0;
            sat_q       <= 1'b0;
            ld_q        <= 1'b0;
            clr_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            sat_hit_q   <= 1'b0;
            remaining_q <= '0;
            steps_q     <= '0;
        end else begin
            ld_q   <= 1'b0;
            clr_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q        <= cmd_dir;
                        sat_q       <= cmd_sat;
                        remaining_q <= cmd_n;
                        steps_q     <= '0;
                        sat_hit_q   <= 1'b0;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                        if (cmd_clr) begin
                            state_q <= S_CLR;
                            clr_q   <= 1'b1;
                        end else if (cmd_n == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (cmd_sat && cmd_dir && at_floor) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            sat_hit_q <= 1'b1;
                        end else begin
                            state_q <= S_STEP;
                            ld_q    <= 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_STEP: begin
                    remaining_q <= remaining_q - ONE;
                    steps_q     <= steps_q + ONE;
                    state_q     <= S_GAP;
                end
                S_GAP: begin
                    if (remaining_q == '0) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else if (sat_q && op_q && at_floor) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        sat_hit_q <= 1'b1;
                    end else begin
                        state_q <= S_STEP;
                        ld_q    <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = ready_q;
    assign op         = op_q;
    assign c_ld       = ld_q;
    assign c_clr      = clr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sat_hit    = sat_hit_q;
    assign steps_done = steps_q;

endmodule

// File: tb/tb_datapath_ctrl.sv
// tb/tb_datapath_ctrl.sv - directed bench with a command-level reference model for datapath_ctrl
module tb_datapath_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_clr = 1'b0;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_n = '0;
    logic             cmd_sat = 1'b0;
    logic             cmd_ready;
    logic             op, c_ld, c_clr, busy, done, sat_hit;
    logic [CNT_W-1:0] steps_done;
    logic [15:0]      c_out;
    logic             z, m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    datapath_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_clr(cmd_clr), .cmd_dir(cmd_dir), .cmd_n(cmd_n), .cmd_sat(cmd_sat),
        .z(z), .m(m), .op(op), .c_ld(c_ld), .c_clr(c_clr), .busy(busy),
        .done(done), .sat_hit(sat_hit), .steps_done(steps_done)
    );

    // Counter datapath being controlled
    always_ff @(posedge clk) begin
        if (reset || c_clr) c_out <= 16'd0;
        else if (c_ld)      c_out <= op ? c_out - 16'd1 : c_out + 16'd1;
    end
    assign z = (c_out == 16'd0);
    assign m = c_out[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: on accept, derive the pulse count k and the command length from the start value
    bit m_ok = 0, m_act = 0;
    int m_c, m_len, m_k;
    bit m_clr, m_dir, m_sat_hit;
    bit l_op, l_sat;
    int l_steps;

    always @(negedge clk) begin
        int avail, n;
        if (m_ok) begin
            if (!m_act) begin
                check("idle ready", cmd_ready, 1);
                check("idle busy", busy, 0);
                check("idle c_ld", c_ld, 0);
                check("idle c_clr", c_clr, 0);
                check("idle done", done, 0);
                check("idle op", op, l_op);
                check("idle steps_done", steps_done, l_steps);
                check("idle sat_hit", sat_hit, l_sat);
            end else begin
                check("run ready", cmd_ready, 0);
                check("run busy", busy, 1);
                check("run c_ld", c_ld, (!m_clr && (m_c % 2 == 1) && (m_c < 2 * m_k)) ? 1 : 0);
                check("run c_clr", c_clr, (m_clr && m_c == 1) ? 1 : 0);
                check("run done", done, (m_c == m_len) ? 1 : 0);
                check("run op", op, m_dir);
                if (m_c == m_len) begin
                    check("done steps_done", steps_done, m_k);
                    check("done sat_hit", sat_hit, m_sat_hit);
                end
            end
        end
        if (reset) begin
            m_ok = 1; m_act = 0; l_op = 0; l_steps = 0; l_sat = 0;
        end else if (m_ok) begin
            if (!m_act) begin
                if (cmd_valid) begin
                    m_act = 1; m_c = 1; m_clr = cmd_clr; m_dir = cmd_dir;
                    if (cmd_clr) begin
                        m_k = 0; m_len = 2; m_sat_hit = 0;
                    end else begin
                        n = int'(cmd_n);
                        if (cmd_sat && cmd_dir) begin
                            avail = (c_out == 16'd0 || c_out[15]) ? 0 : int'(c_out);
                            m_k = (n < avail) ? n : avail;
                        end else begin
                            m_k = n;
                        end
                        m_sat_hit = cmd_sat && cmd_dir && (m_k < n);
                        m_len = 2 * m_k + 1;
                    end
                end
            end else if (m_c == m_len) begin
                m_act = 0; l_op = m_dir; l_steps = m_k; l_sat = m_sat_hit;
            end else begin
                m_c++;
            end
        end
    end

    task automatic issue(input bit clr, input bit dir, input logic [CNT_W-1:0] n, input bit sat);
        cmd_clr = clr; cmd_dir = dir; cmd_n = n; cmd_sat = sat; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(output int dc, output int np, output int nc);
        dc = -1; np = 0; nc = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            np += int'(c_ld);
            nc += int'(c_clr);
            if (done) begin
                dc = k;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input string name, input bit clr, input bit dir, input logic [CNT_W-1:0] n,
                       input bit sat, input int exp_dc, input int exp_np);
        int dc, np, nc;
        issue(clr, dir, n, sat);
        wait_done(dc, np, nc);
        check({name, " done cycle"}, dc, exp_dc);
        check({name, " c_ld pulses"}, np, exp_np);
        check({name, " c_clr pulses"}, nc, clr ? 1 : 0);
    endtask

    initial begin
        int dc, np, nc, nd;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset cmd_ready", cmd_ready, 1);
        check("reset busy", busy, 0);
        check("reset c_ld", c_ld, 0);
        check("reset c_clr", c_clr, 0);
        check("reset done", done, 0);
        check("reset op", op, 0);
        check("reset steps_done", steps_done, 0);
        check("reset sat_hit", sat_hit, 0);
        reset = 1'b0;

        run("clear", 1, 0, 8'd0, 0, 2, 0);
        check("clear c_out", c_out, 0);

        run("up3", 0, 0, 8'd3, 0, 7, 3);
        check("up3 c_out", c_out, 3);
        check("up3 steps_done", steps_done, 3);
        check("up3 sat_hit", sat_hit, 0);

        run("down5 sat", 0, 1, 8'd5, 1, 7, 3);
        check("down5 c_out", c_out, 0);
        check("down5 z", z, 1);
        check("down5 sat_hit", sat_hit, 1);
        check("down5 steps_done", steps_done, 3);

        run("down2 wrap", 0, 1, 8'd2, 0, 5, 2);
        check("down2 c_out", c_out, 65534);
        check("down2 m", m, 1);

        run("down1 sat neg", 0, 1, 8'd1, 1, 1, 0);
        check("down1 sat_hit", sat_hit, 1);
        check("down1 steps_done", steps_done, 0);
        check("down1 c_out", c_out, 65534);

        run("clear2", 1, 0, 8'd0, 0, 2, 0);
        run("up0", 0, 0, 8'd0, 0, 1, 0);
        check("up0 sat_hit", sat_hit, 0);
        check("up0 c_out", c_out, 0);

        // Second command held on cmd_valid while the first is busy
        cmd_clr = 0; cmd_dir = 0; cmd_n = 8'd4; cmd_sat = 0; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_n = 8'd2;
        wait_done(dc, np, nc);
        check("held first done cycle", dc, 9);
        check("held first pulses", np, 4);
        check("held idle ready", cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_done(dc, np, nc);
        check("held second done cycle", dc, 5);
        check("held second pulses", np, 2);
        check("held c_out", c_out, 6);

        run("down2 sat exact", 0, 1, 8'd2, 1, 5, 2);
        check("down2 sat c_out", c_out, 4);
        check("down2 sat sat_hit", sat_hit, 0);
        check("down2 sat steps_done", steps_done, 2);

        // Reset during cycle 3 of an up-4 command
        issue(0, 0, 8'd4, 0);
        np = 0; nd = 0;
        for (int k = 1; k <= 3; k++) begin
            if (k == 3) reset = 1'b1;
            @(negedge clk);
            np += int'(c_ld);
            nd += int'(done);
            @(posedge clk); #1;
        end
        check("rst pulses", np, 2);
        check("rst done seen", nd, 0);
        check("rst cmd_ready", cmd_ready, 1);
        check("rst busy", busy, 0);
        check("rst c_ld", c_ld, 0);
        check("rst steps_done", steps_done, 0);
        reset = 1'b0;
        np = 0; nd = 0;
        repeat (10) begin
            @(negedge clk);
            np += int'(c_ld);
            nd += int'(done);
        end
        check("post-rst pulses", np, 0);
        check("post-rst done", nd, 0);
        check("post-rst c_out", c_out, 0);

        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
